// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, state encoding and packing helper for the matrix loader
package matrix_pkg;
    localparam int DIM = 5;
    localparam int EW  = 8;
    localparam int MW  = DIM * DIM * EW;
    localparam logic [2:0] MIN_SIZE = 3'd2;
    localparam logic [2:0] MAX_SIZE = 3'd5;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        DONE   = 2'd3
    } state_t;
    function automatic logic [7:0] bit_off(input logic [2:0] r, input logic [2:0] c);
        return 8'(MW - EW * (int'(r) * DIM + int'(c) + 1));
    endfunction
endpackage

// File: rtl/mat_idx_counter.sv
// mat_idx_counter: row-major (r,c) walker over an NxN sub-grid, wraps to (0,0) after the last cell
module mat_idx_counter
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic [2:0] size,
    output logic [2:0] r,
    output logic [2:0] c,
    output logic       last
);
    logic [2:0] r_row, r_col;
    logic       w_row_end;
    assign w_row_end = r_col == size - 3'd1;
    assign last      = w_row_end && r_row == size - 3'd1;
    assign r         = r_row;
    assign c         = r_col;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            r_col <= w_row_end ? 3'd0 : r_col + 3'd1;
            r_row <= last ? 3'd0 : w_row_end ? r_row + 3'd1 : r_row;
        end
    end
endmodule

// File: rtl/matrix_loader.sv
// matrix_loader: streams A then B elements into zero-padded 5x5 packed operands for the multiplier
module matrix_loader
    import matrix_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    mat_size,
    input  logic [EW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [MW-1:0] lin,
    output logic [MW-1:0] col,
    output logic          mat_valid,
    input  logic          mat_ack,
    output logic          busy,
    output logic          err
);
    state_t        r_state, w_next;
    logic [2:0]    r_size, w_r, w_c;
    logic [MW-1:0] r_lin, r_col;
    logic          r_mat_valid, r_err, w_legal, w_go, w_beat, w_last;
    assign w_legal   = mat_size >= MIN_SIZE && mat_size <= MAX_SIZE;
    assign w_go      = r_state == IDLE && start && w_legal;
    assign in_ready  = r_state == LOAD_A || r_state == LOAD_B;
    assign w_beat    = in_valid && in_ready;
    assign busy      = r_state != IDLE;
    assign lin       = r_lin;
    assign col       = r_col;
    assign mat_valid = r_mat_valid;
    assign err       = r_err;
    mat_idx_counter u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_go),
        .inc  (w_beat),
        .size (r_size),
        .r    (w_r),
        .c    (w_c),
        .last (w_last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go ? LOAD_A : IDLE;
            LOAD_A:  w_next = w_beat && w_last ? LOAD_B : LOAD_A;
            LOAD_B:  w_next = w_beat && w_last ? DONE : LOAD_B;
            default: w_next = mat_ack ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size      <= '0;
            r_lin       <= '0;
            r_col       <= '0;
            r_mat_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mat_valid <= w_next == DONE;
            r_err       <= r_state == IDLE && start && !w_legal;
            if (w_go) begin
                r_size <= mat_size;
                r_lin  <= '0;
                r_col  <= '0;
            end
            if (w_beat && r_state == LOAD_A) r_lin[bit_off(w_r, w_c) +: EW] <= in_data;
            if (w_beat && r_state == LOAD_B) r_col[bit_off(w_r, w_c) +: EW] <= in_data;
        end
    end
endmodule
